// File: rtl/hid_pkg.sv
// Shared definitions for the HID peripheral: attached-device class codes,
// LED bit positions, output-report FSM encoding and the status word layout.
package hid_pkg;

  localparam logic [1:0] USB_TYPE_NONE    = 2'd0;
  localparam logic [1:0] USB_TYPE_KBD     = 2'd1;
  localparam logic [1:0] USB_TYPE_MOUSE   = 2'd2;
  localparam logic [1:0] USB_TYPE_GAMEPAD = 2'd3;

  localparam int LED_NUM     = 0;
  localparam int LED_CAPS    = 1;
  localparam int LED_SCROLL  = 2;
  localparam int LED_COMPOSE = 3;
  localparam int LED_KANA    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } tx_state_t;

  // Bit positions within the CPU-visible status word.
  localparam int STAT_KBD     = 0;
  localparam int STAT_BUSY    = 1;
  localparam int STAT_PENDING = 2;
  localparam int STAT_ERR     = 3;

  function automatic logic [15:0] pack_status(
    input logic [7:0] led_current,
    input logic [2:0] retry_cnt,
    input logic       err,
    input logic       pending,
    input logic       busy,
    input logic       kbd_present
  );
    return {led_current, 1'b0, retry_cnt, err, pending, busy, kbd_present};
  endfunction

endpackage

// File: rtl/hid_out_timer.sv
// Per-state cycle counter for the output-report FSM; flags the terminal count
// of either the attempt timeout or the inter-attempt gap.
module hid_out_timer #(
  parameter int TIMEOUT_CYCLES = 1_200_000,
  parameter int GAP_CYCLES     = 12_000,
  parameter int TW             = 21
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic sel_gap,
  output logic tc
);

  localparam logic [TW-1:0] TIMEOUT_TC = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] GAP_TC     = TW'(GAP_CYCLES - 1);

  logic [TW-1:0] count;

  assign tc = (count == (sel_gap ? GAP_TC : TIMEOUT_TC));

  // Saturates at the terminal count so a stalled FSM cannot wrap the timer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (!tc) begin
      count <= count + TW'(1);
    end
  end

endmodule

// File: rtl/hid_led_report_tx.sv
// Keyboard LED output-report transmitter: CPU writes, req/ack handshake with the
// host engine, timeout + bounded retry, coalescing. Option: HID_LED_AUTO_RESEND_EN.
module hid_led_report_tx
  import hid_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_200_000,
  parameter int GAP_CYCLES     = 12_000,
  parameter int MAX_RETRIES    = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cpu_valid,
  input  logic        cpu_wrstrb,
  input  logic        cpu_rdstrb,
  input  logic [7:0]  cpu_wdata,
  input  logic [1:0]  usb_type,
  output logic        out_req,
  output logic [7:0]  out_data,
  input  logic        out_ack,
  input  logic        out_err,
  output logic [15:0] LED_status
);

  localparam int TMAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [2:0] MAX_RETRY_CNT = 3'(MAX_RETRIES);

  tx_state_t  state, state_next;
  logic [7:0] led_shadow;
  logic [7:0] led_current;
  logic       pending;
  logic       err;
  logic [2:0] retry_cnt;

  logic kbd_present;
  logic cpu_wr;
  logic cpu_rd;
  logic timer_tc;
  logic timer_clear;
  logic take_shadow;
  logic ack_done;
  logic retry;
  logic give_up;
  logic abort;
  logic auto_resend;

  assign kbd_present = (usb_type == USB_TYPE_KBD);
  assign cpu_wr      = cpu_valid && cpu_wrstrb;
  assign cpu_rd      = cpu_valid && cpu_rdstrb;
  assign out_req     = (state == ST_REQ);
  assign timer_clear = (state_next != state) || (state == ST_IDLE);

  hid_out_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .GAP_CYCLES     (GAP_CYCLES),
    .TW             (TW)
  ) u_timer (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (timer_clear),
    .sel_gap (state == ST_GAP),
    .tc      (timer_tc)
  );

`ifdef HID_LED_AUTO_RESEND_EN
  logic kbd_prev;

  // Replug detection: a fresh keyboard gets the last LED byte re-sent.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      kbd_prev <= 1'b0;
    end else begin
      kbd_prev <= kbd_present;
    end
  end

  assign auto_resend = kbd_present && !kbd_prev;
`else
  assign auto_resend = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A completed ack beats a simultaneous unplug, error or timeout.
  always_comb begin
    state_next  = state;
    take_shadow = 1'b0;
    ack_done    = 1'b0;
    retry       = 1'b0;
    give_up     = 1'b0;
    abort       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pending && kbd_present) begin
          state_next  = ST_REQ;
          take_shadow = 1'b1;
        end
      end
      ST_REQ: begin
        if (out_ack) begin
          ack_done   = 1'b1;
          state_next = ST_IDLE;
        end else if (!kbd_present) begin
          abort      = 1'b1;
          state_next = ST_IDLE;
        end else if (out_err || timer_tc) begin
          if (retry_cnt < MAX_RETRY_CNT) begin
            retry      = 1'b1;
            state_next = ST_GAP;
          end else begin
            give_up    = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (!kbd_present) begin
          abort      = 1'b1;
          state_next = ST_IDLE;
        end else if (timer_tc) begin
          state_next  = ST_REQ;
          take_shadow = pending;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A write landing in the same cycle as a take keeps the new byte pending.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      led_shadow  <= 8'h00;
      led_current <= 8'h00;
      out_data    <= 8'h00;
      pending     <= 1'b0;
      err         <= 1'b0;
      retry_cnt   <= 3'd0;
    end else begin
      if (cpu_wr) begin
        led_shadow <= cpu_wdata;
      end
      if (cpu_wr || abort || auto_resend) begin
        pending <= 1'b1;
      end else if (take_shadow) begin
        pending <= 1'b0;
      end
      if (take_shadow) begin
        out_data  <= led_shadow;
        retry_cnt <= 3'd0;
      end else if (retry) begin
        retry_cnt <= retry_cnt + 3'd1;
      end
      if (ack_done) begin
        led_current <= out_data;
      end
      if (give_up) begin
        err <= 1'b1;
      end else if (cpu_wr || cpu_rd) begin
        err <= 1'b0;
      end
    end
  end

  assign LED_status = pack_status(led_current, retry_cnt, err, pending,
                                  state != ST_IDLE, kbd_present);

endmodule

// File: tb/tb_hid_led_report_tx.sv
// Self-checking bench for hid_led_report_tx with short timeout/gap values; a
// queue of expected report bytes is checked whenever the bench acks a transfer.
module tb_hid_led_report_tx;

  localparam int TIMEOUT = 50;
  localparam int GAP     = 10;
  localparam int RETRIES = 3;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cpu_valid = 1'b0;
  logic        cpu_wrstrb = 1'b0;
  logic        cpu_rdstrb = 1'b0;
  logic [7:0]  cpu_wdata = 8'h00;
  logic [1:0]  usb_type = 2'd0;
  logic        out_req;
  logic [7:0]  out_data;
  logic        out_ack = 1'b0;
  logic        out_err = 1'b0;
  logic [15:0] LED_status;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  hid_led_report_tx #(
    .TIMEOUT_CYCLES (TIMEOUT),
    .GAP_CYCLES     (GAP),
    .MAX_RETRIES    (RETRIES)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .cpu_valid  (cpu_valid),
    .cpu_wrstrb (cpu_wrstrb),
    .cpu_rdstrb (cpu_rdstrb),
    .cpu_wdata  (cpu_wdata),
    .usb_type   (usb_type),
    .out_req    (out_req),
    .out_data   (out_data),
    .out_ack    (out_ack),
    .out_err    (out_err),
    .LED_status (LED_status)
  );

  always #5 clk = ~clk;

  // Scoreboard: every acked transfer must carry the oldest expected byte.
  always @(negedge clk) begin
    if (rstn && out_req && out_ack) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL scoreboard_unexpected: out_data=%h acked, no byte expected", out_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("[TB] FAIL scoreboard_data: out_data=%h required %h", out_data, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [7:0] b);
    cpu_valid  = 1'b1;
    cpu_wrstrb = 1'b1;
    cpu_wdata  = b;
    step(1);
    cpu_valid  = 1'b0;
    cpu_wrstrb = 1'b0;
  endtask

  task automatic pulse_ack();
    out_ack = 1'b1;
    step(1);
    out_ack = 1'b0;
  endtask

  task automatic wait_req(input int budget, input string name);
    int n = 0;
    while (out_req !== 1'b1 && n < budget) begin
      step(1);
      n++;
    end
    checks++;
    if (out_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s: out_req=%b after %0d cycles, required 1", name, out_req, budget);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    usb_type = 2'd1;
    step(3);
    checks++;
    if (out_req !== 1'b0 || out_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_outputs: out_req=%b out_data=%h required 0/00", out_req, out_data);
    end
    checks++;
    if (LED_status !== 16'h0001) begin
      errors++;
      $display("[TB] FAIL reset_status: LED_status=%h required 0001", LED_status);
    end
    rstn = 1'b1;
`ifdef HID_LED_AUTO_RESEND_EN
    exp_q.push_back(8'h00);
    wait_req(10, "reset_autoresend_req");
    pulse_ack();
`endif
    step(3);
    checks++;
    if (LED_status !== 16'h0001 || out_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: LED_status=%h out_req=%b required 0001/0", LED_status, out_req);
    end
  endtask

  task automatic test_single();
    exp_q.push_back(8'h02);
    cpu_write(8'h02);
    checks++;
    if (LED_status[2] !== 1'b1 || out_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_pending: pending=%b out_req=%b required 1/0", LED_status[2], out_req);
    end
    step(1);
    checks++;
    if (out_req !== 1'b1 || out_data !== 8'h02) begin
      errors++;
      $display("[TB] FAIL single_req_latency: out_req=%b out_data=%h required 1/02", out_req, out_data);
    end
    step(4);
    pulse_ack();
    checks++;
    if (out_req !== 1'b0 || LED_status !== 16'h0201) begin
      errors++;
      $display("[TB] FAIL single_done: out_req=%b LED_status=%h required 0/0201", out_req, LED_status);
    end
  endtask

  task automatic test_retry_exhaust();
    int pulses = 0;
    int run = 0;
    logic prev = 1'b0;
    int lens[$];
    int gaps[$];
    cpu_write(8'h5A);
    for (int i = 0; i < 300; i++) begin
      if (out_req === prev) begin
        run++;
      end else begin
        if (prev) lens.push_back(run);
        else if (pulses > 0) gaps.push_back(run);
        if (out_req) pulses++;
        run = 1;
        prev = out_req;
      end
      step(1);
    end
    checks++;
    if (pulses != RETRIES + 1 || lens.size() != RETRIES + 1 || gaps.size() != RETRIES) begin
      errors++;
      $display("[TB] FAIL exhaust_pulses: pulses=%0d lens=%0d gaps=%0d required 4/4/3",
               pulses, lens.size(), gaps.size());
    end
    foreach (lens[k]) begin
      checks++;
      if (lens[k] != TIMEOUT) begin
        errors++;
        $display("[TB] FAIL exhaust_pulse_len[%0d]: %0d cycles required %0d", k, lens[k], TIMEOUT);
      end
    end
    foreach (gaps[k]) begin
      checks++;
      if (gaps[k] != GAP) begin
        errors++;
        $display("[TB] FAIL exhaust_gap_len[%0d]: %0d cycles required %0d", k, gaps[k], GAP);
      end
    end
    checks++;
    if (LED_status !== 16'h0239) begin
      errors++;
      $display("[TB] FAIL exhaust_status: LED_status=%h required 0239", LED_status);
    end
    cpu_valid = 1'b1;
    cpu_rdstrb = 1'b1;
    checks++;
    if (LED_status[3] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL read1_err: err=%b required 1", LED_status[3]);
    end
    step(1);
    checks++;
    if (LED_status[3] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read2_err: err=%b required 0", LED_status[3]);
    end
    step(1);
    cpu_valid = 1'b0;
    cpu_rdstrb = 1'b0;
  endtask

  task automatic test_coalesce();
    int extra = 0;
    exp_q.push_back(8'h01);
    cpu_write(8'h01);
    wait_req(5, "coalesce_req1");
    cpu_write(8'h03);
    cpu_write(8'h07);
    exp_q.push_back(8'h07);
    checks++;
    if (out_data !== 8'h01 || out_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL coalesce_hold: out_data=%h out_req=%b required 01/1", out_data, out_req);
    end
    pulse_ack();
    wait_req(5, "coalesce_req2");
    pulse_ack();
    for (int i = 0; i < 10; i++) begin
      if (out_req) extra++;
      step(1);
    end
    checks++;
    if (extra != 0 || LED_status !== 16'h0701) begin
      errors++;
      $display("[TB] FAIL coalesce_single_extra: extra req cycles=%0d LED_status=%h required 0/0701",
               extra, LED_status);
    end
  endtask

  task automatic test_err_retry();
    exp_q.push_back(8'h10);
    cpu_write(8'h10);
    wait_req(5, "errretry_req1");
    step(2);
    out_err = 1'b1;
    step(1);
    out_err = 1'b0;
    checks++;
    if (out_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL errretry_drop: out_req=%b required 0", out_req);
    end
    wait_req(GAP + 5, "errretry_req2");
    pulse_ack();
    checks++;
    if (LED_status !== 16'h1011) begin
      errors++;
      $display("[TB] FAIL errretry_status: LED_status=%h required 1011", LED_status);
    end
  endtask

  task automatic test_unplug();
    int stray = 0;
    exp_q.push_back(8'h44);
    cpu_write(8'h44);
    wait_req(5, "unplug_req1");
    step(1);
    usb_type = 2'd0;
    step(1);
    checks++;
    if (out_req !== 1'b0 || LED_status[3:0] !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL unplug_abort: out_req=%b status[3:0]=%b required 0/0100", out_req, LED_status[3:0]);
    end
    for (int i = 0; i < 5; i++) begin
      if (out_req) stray++;
      step(1);
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("[TB] FAIL unplug_quiet: out_req high %0d cycles required 0", stray);
    end
    usb_type = 2'd1;
    wait_req(5, "unplug_resend");
    pulse_ack();
  endtask

  task automatic test_replug_idle();
    int reqs = 0;
    usb_type = 2'd0;
    step(3);
    usb_type = 2'd1;
`ifdef HID_LED_AUTO_RESEND_EN
    exp_q.push_back(8'h44);
    wait_req(5, "replug_autoresend");
    pulse_ack();
`else
    for (int i = 0; i < 20; i++) begin
      if (out_req) reqs++;
      step(1);
    end
    checks++;
    if (reqs != 0) begin
      errors++;
      $display("[TB] FAIL replug_no_resend: out_req high %0d cycles required 0", reqs);
    end
`endif
    step(2);
    checks++;
    if (LED_status !== 16'h4401) begin
      errors++;
      $display("[TB] FAIL replug_status: LED_status=%h required 4401", LED_status);
    end
  endtask

  task automatic test_ack_write_same();
    exp_q.push_back(8'h21);
    cpu_write(8'h21);
    wait_req(5, "ackwr_req1");
    step(2);
    exp_q.push_back(8'h22);
    out_ack = 1'b1;
    cpu_valid = 1'b1;
    cpu_wrstrb = 1'b1;
    cpu_wdata = 8'h22;
    step(1);
    out_ack = 1'b0;
    cpu_valid = 1'b0;
    cpu_wrstrb = 1'b0;
    checks++;
    if (LED_status[15:8] !== 8'h21 || LED_status[2] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ackwr_old: led_current=%h pending=%b required 21/1", LED_status[15:8], LED_status[2]);
    end
    wait_req(5, "ackwr_req2");
    pulse_ack();
    checks++;
    if (LED_status !== 16'h2201) begin
      errors++;
      $display("[TB] FAIL ackwr_new: LED_status=%h required 2201", LED_status);
    end
  endtask

  task automatic test_stray_handshake();
    out_ack = 1'b1;
    out_err = 1'b1;
    step(1);
    out_ack = 1'b0;
    out_err = 1'b0;
    step(2);
    checks++;
    if (LED_status !== 16'h2201 || out_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stray_ignored: LED_status=%h out_req=%b required 2201/0", LED_status, out_req);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d bytes never transferred, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_retry_exhaust();
    test_coalesce();
    test_err_retry();
    test_unplug();
    test_replug_idle();
    test_ack_write_same();
    test_stray_handshake();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hid_led_report_tx.md
# hid_led_report_tx

Host-to-device output-report transmitter for the keyboard path of the USB HID peripheral. It accepts LED writes from the RVLeon CPU (Num/Caps/Scroll/Compose/Kana bits) and runs a request/acknowledge handshake with the USB host engine, which issues the SET_REPORT transfer. It adds timeout, bounded retry with inter-attempt gap, last-write-wins coalescing, and a CPU-readable status word, and sits beside the keyboard/mouse report reader in the HID peripheral wrapper.

## Interface
- TIMEOUT_CYCLES, 1_200_000, clk cycles to wait for out_ack/out_err per attempt (100 ms at 12 MHz)
- GAP_CYCLES, 12_000, idle cycles between a failed attempt and the retry (1 ms)
- MAX_RETRIES, 3, retries after the first attempt before giving up (range 0..7)
- clk  in  1  USB/peripheral clock, single domain
- rstn  in  1  asynchronous active-low reset
- cpu_valid  in  1  CPU access targets this block
- cpu_wrstrb  in  1  write strobe; write accepted when cpu_valid && cpu_wrstrb
- cpu_rdstrb  in  1  read strobe; status read when cpu_valid && cpu_rdstrb
- cpu_wdata  in  8  LED byte (bits 7:5 forwarded unchanged)
- usb_type  in  2  attached device class from host engine; 2'd1 = keyboard
- out_req  out  1  request to host engine to send out_data as output report
- out_data  out  8  report byte, stable while out_req=1
- out_ack  in  1  1-cycle pulse: transfer completed
- out_err  in  1  1-cycle pulse: transfer failed (NAK/STALL/CRC)
- LED_status  out  16  {led_current[7:0], 1'b0, retry_cnt[2:0], err, pending, busy, kbd_present}

## Operation
- Registers: led_shadow (last CPU write), led_current (last acknowledged byte), pending, err (sticky), retry_cnt, timer.
- States: IDLE, REQ, GAP.
- IDLE: if pending && kbd_present -> REQ, out_data<=led_shadow, pending<=0, retry_cnt<=0.
- CPU write: led_shadow<=cpu_wdata, pending<=1, err<=0. In REQ/GAP the write only updates shadow/pending (last write wins); active attempt continues with its latched out_data.
- REQ: out_req=1. out_ack -> led_current<=out_data, IDLE. out_err or timer==TIMEOUT_CYCLES-1 -> if retry_cnt<MAX_RETRIES: retry_cnt++, GAP; else err<=1, IDLE.
- GAP: out_req=0; after GAP_CYCLES -> REQ, out_data<=led_shadow if pending (pending<=0, retry_cnt<=0), else same byte.
- kbd_present = (usb_type==2'd1). Its deassertion in REQ/GAP aborts: out_req drops next cycle, IDLE, pending<=1 (byte re-sent when a keyboard returns), no err.
- Status read clears err after the read cycle (read returns err=1 once).
- Simultaneous out_ack and CPU write: ack completes old byte, new byte stays pending, REQ again via IDLE.
- out_ack and out_err in the same cycle: ack wins. Ack/err outside REQ ignored.

## Timing
- Reset: all registers 0; out_req=0, out_data=8'h00, LED_status=16'h0000 (kbd_present follows usb_type combinationally).
- Write at cycle N -> pending visible in LED_status at N+1; out_req high at N+2 when IDLE with keyboard present.
- out_req falls the cycle after ack/err/timeout is sampled; earliest re-request after failure = GAP_CYCLES+1 cycles.
- busy = state!=IDLE. timer reset on every state entry; width $clog2(max(TIMEOUT_CYCLES,GAP_CYCLES)).
- Reset asserted mid-transfer: out_req drops asynchronously; led_shadow lost.

## Configuration
- HID_LED_AUTO_RESEND_EN defined: on rising edge of kbd_present, pending<=1 so led_shadow is re-sent to a newly attached keyboard (restores Caps/Num state after replug).
- Undefined: reconnect does nothing; only a CPU write or an aborted transfer sets pending.

## Structure
- Shared package hid_pkg: USB_TYPE_NONE/KBD/MOUSE/GAMEPAD constants, LED bit positions, state encoding for IDLE/REQ/GAP.
- One sub-module: hid_out_timer (load/clear, terminal-count compare for TIMEOUT and GAP).

## Test plan
- usb_type=1, write 8'h02, ack 5 cycles after out_req -> out_data=8'h02, led_current=8'h02, busy=0, err=0.
- Never ack, MAX_RETRIES=3, TIMEOUT_CYCLES=50, GAP_CYCLES=10 -> exactly 4 out_req pulses of 50 cycles, 10-cycle gaps, err=1, retry_cnt=3; one status read -> err returns 1, next read 0.
- Writes 8'h01, 8'h03, 8'h07 during one REQ -> current attempt keeps 8'h01; after ack exactly one more transfer with 8'h07.
- out_err on first attempt, ack on second -> retry_cnt=1, led_current updated, err=0.
- usb_type 1->0 during REQ -> out_req low next cycle, pending=1; usb_type->1 -> byte re-sent; with HID_LED_AUTO_RESEND_EN, replug with idle block re-sends led_shadow, without it no out_req.
- Write and out_ack same cycle -> led_current=old byte, second transfer carries new byte.
